// File: rtl/keccak_padder_64.sv
// Keccak/SHA-3 multi-rate padder for 64-bit lanes.
// Streams message words through a one-entry registered output stage.
// It places the domain/pad-start byte after the last message byte and
// sets bit 63 of the final lane of the closing block. It also emits
// whole padding words, or an extra block, when the message alone does
// not close the block.
module keccak_padder_64 #(
    parameter int unsigned DIN_WIDTH  = 64,
    parameter int unsigned RATE_WORDS = 17,
    parameter logic [7:0]  PAD_BYTE   = 8'h06
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIN_WIDTH-1:0] in_data,
    input  logic [3:0]           in_bytes,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIN_WIDTH-1:0] out,
    output logic                 first_block,
    output logic                 last_block
);

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PAD
    } state_t;

    localparam int unsigned   NBYTES = DIN_WIDTH / 8;
    localparam logic [4:0]    LAST_W = 5'(RATE_WORDS - 1);

    state_t               state_q, state_d;
    logic [4:0]           wcnt_q, wcnt_d;
    logic [DIN_WIDTH-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic                 fb_run_q, fb_run_d;   // current block is the message's first block
    logic                 placed_q, placed_d;   // PAD_BYTE already emitted for this message

    logic                 slot_free;
    logic                 in_ready_int;
    logic                 in_fire;
    logic                 pad_fire;
    logic                 end_of_block;
    logic                 fb_now;
    logic [DIN_WIDTH-1:0] in_word;
    logic [DIN_WIDTH-1:0] pad_word;

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign first_block = first_q;
    assign last_block  = last_q;
    assign in_ready    = rst_n & in_ready_int;

    // Handshake qualifiers and the candidate words for the output stage
    always_comb begin
        slot_free    = !out_valid_q || out_ready;
        in_ready_int = (state_q != PAD) && slot_free;
        in_fire      = in_valid && in_ready_int;
        pad_fire     = (state_q == PAD) && slot_free;
        end_of_block = (wcnt_q == LAST_W);
        fb_now       = (state_q == IDLE) ? 1'b1 : fb_run_q;

        in_word = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (!in_last || (4'(i) < in_bytes)) begin
                in_word[i*8 +: 8] = in_data[i*8 +: 8];
            end else if (4'(i) == in_bytes) begin
                in_word[i*8 +: 8] = PAD_BYTE;
            end
        end
        if (in_last && (in_bytes < 4'd8) && end_of_block) begin
            in_word[DIN_WIDTH-1] = 1'b1;
        end

        pad_word = '0;
        if (!placed_q) begin
            pad_word[7:0] = PAD_BYTE;
        end
        if (end_of_block) begin
            pad_word[DIN_WIDTH-1] = 1'b1;
        end
    end

    // Next-state and output-stage load logic
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        first_d     = first_q;
        last_d      = last_q;
        fb_run_d    = fb_run_q;
        placed_d    = placed_q;

        if (in_fire) begin
            out_valid_d = 1'b1;
            out_d       = in_word;
            first_d     = fb_now;
            fb_run_d    = end_of_block ? 1'b0 : fb_now;
            wcnt_d      = end_of_block ? '0 : wcnt_q + 5'd1;
            if (!in_last) begin
                last_d  = 1'b0;
                state_d = MSG;
            end else if (in_bytes < 4'd8) begin
                last_d   = 1'b1;
                placed_d = 1'b1;
                state_d  = end_of_block ? IDLE : PAD;
            end else begin
                // Full final word: the pad byte starts the next word, which
                // may open a fresh block when this word closed the current one.
                last_d   = 1'b0;
                placed_d = 1'b0;
                state_d  = PAD;
            end
        end else if (pad_fire) begin
            out_valid_d = 1'b1;
            out_d       = pad_word;
            first_d     = fb_run_q;
            last_d      = 1'b1;
            placed_d    = 1'b1;
            fb_run_d    = end_of_block ? 1'b0 : fb_run_q;
            wcnt_d      = end_of_block ? '0 : wcnt_q + 5'd1;
            if (end_of_block) begin
                state_d = IDLE;
            end
        end
    end

    // State and output-stage registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            fb_run_q    <= 1'b0;
            placed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            fb_run_q    <= fb_run_d;
            placed_q    <= placed_d;
        end
    end

endmodule

// File: tb/tb_keccak_padder_64.sv
// Directed bench for keccak_padder_64: a table of messages with
// hand-chosen pad positions, plus explicit spot checks on key words.
module tb_keccak_padder_64;

    localparam int unsigned NONE = 999;
    localparam logic [7:0]  PADB = 8'h06;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [3:0]  in_bytes;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    logic        first_block;
    logic        last_block;

    keccak_padder_64 #(
        .DIN_WIDTH (64),
        .RATE_WORDS(17),
        .PAD_BYTE  (8'h06)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_bytes   (in_bytes),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .first_block(first_block),
        .last_block (last_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned nbytes;     // message length in bytes
        logic        abc;        // use "abc..." byte values instead of the pattern
        int unsigned exp_words;  // expected output words
        int unsigned pad_word;   // word index holding PAD_BYTE
        int unsigned pad_byte;   // byte lane of PAD_BYTE
        int unsigned stall_at;   // output word index at which out_ready drops
        int unsigned stall_len;  // cycles of out_ready low
        int unsigned rst_at;     // output word index at which reset is pulsed
    } vec_t;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [63:0] rx [0:63];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] msgb(input logic abc, input int unsigned n);
        logic [7:0] b;
        if (abc) b = 8'(8'h61 + n);
        else     b = 8'((n * 7 + 3) & 8'hff);
        return b;
    endfunction

    function automatic logic [63:0] in_word(input vec_t v, input int unsigned k);
        logic [63:0] w;
        for (int unsigned j = 0; j < 8; j++) begin
            if (k * 8 + j < v.nbytes) w[j*8 +: 8] = msgb(v.abc, k * 8 + j);
            else                      w[j*8 +: 8] = 8'hEE;  // garbage that must be ignored
        end
        return w;
    endfunction

    function automatic logic [63:0] exp_word(input vec_t v, input int unsigned k);
        logic [63:0] w;
        for (int unsigned j = 0; j < 8; j++) begin
            if (k * 8 + j < v.nbytes)                   w[j*8 +: 8] = msgb(v.abc, k * 8 + j);
            else if (k == v.pad_word && j == v.pad_byte) w[j*8 +: 8] = PADB;
            else                                        w[j*8 +: 8] = 8'h00;
        end
        if (k == v.exp_words - 1) w[63] = 1'b1;
        return w;
    endfunction

    task automatic run_msg(input vec_t v);
        int unsigned nw_in;
        int unsigned sent;
        int unsigned rcvd;
        int unsigned stall_cnt;
        int unsigned cyc;
        logic        stalling;
        nw_in     = (v.nbytes == 0) ? 1 : (v.nbytes + 7) / 8;
        sent      = 0;
        rcvd      = 0;
        stall_cnt = 0;
        cyc       = 0;
        while (rcvd < v.exp_words && cyc < 300) begin
            @(negedge clk);
            if (rcvd == v.rst_at) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                #1;
                chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
                chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
                chk("rst_mid_out", out, 64'd0);
                chk("rst_mid_flags", {62'd0, first_block, last_block}, 64'd0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            stalling  = (rcvd == v.stall_at) && (stall_cnt < v.stall_len);
            out_ready = !stalling;
            if (sent < nw_in) begin
                in_valid = 1'b1;
                in_data  = in_word(v, sent);
                in_last  = (sent == nw_in - 1);
                in_bytes = (sent == nw_in - 1) ? 4'(v.nbytes - 8 * (nw_in - 1)) : 4'd8;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_bytes = 4'd0;
                in_data  = '0;
            end
            #1;
            if (stalling) begin
                stall_cnt++;
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_out_held", out, exp_word(v, rcvd));
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("len%0d_w%0d_data", v.nbytes, rcvd), out, exp_word(v, rcvd));
                chk($sformatf("len%0d_w%0d_first", v.nbytes, rcvd), 64'(first_block), 64'(rcvd < 17));
                chk($sformatf("len%0d_w%0d_last", v.nbytes, rcvd), 64'(last_block), 64'(rcvd >= v.pad_word));
                rx[rcvd] = out;
                rcvd++;
            end
            cyc++;
        end
        if (rcvd < v.exp_words) begin
            chk($sformatf("len%0d_timeout_words", v.nbytes), 64'(rcvd), 64'(v.exp_words));
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("after_msg_out_valid", 64'(out_valid), 64'd0);
            chk("after_msg_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    vec_t vecs [0:9];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bytes  = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        //        nbytes abc words padw padb stall len rst
        vecs[0] = '{0,   1'b0, 17, 0,  0, NONE, 0, NONE};
        vecs[1] = '{3,   1'b1, 17, 0,  3, NONE, 0, NONE};
        vecs[2] = '{8,   1'b0, 17, 1,  0, NONE, 0, NONE};
        vecs[3] = '{13,  1'b0, 17, 1,  5, NONE, 0, NONE};
        vecs[4] = '{135, 1'b0, 17, 16, 7, NONE, 0, NONE};
        vecs[5] = '{136, 1'b0, 34, 17, 0, NONE, 0, NONE};
        vecs[6] = '{200, 1'b0, 34, 25, 0, NONE, 0, NONE};
        vecs[7] = '{71,  1'b0, 17, 8,  7, 8,    5, NONE};
        vecs[8] = '{0,   1'b0, 17, 0,  0, NONE, 0, 10};
        vecs[9] = '{3,   1'b1, 17, 0,  3, NONE, 0, NONE};

        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out", out, 64'd0);
        chk("reset_first", 64'(first_block), 64'd0);
        chk("reset_last", 64'(last_block), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_msg(vecs[i]);
            if (i == 0) begin
                chk("empty_w0", rx[0], 64'h0000000000000006);
                chk("empty_w16", rx[16], 64'h8000000000000000);
            end
            if (i == 1 || i == 9) begin
                chk("abc_w0", rx[0], 64'h0000000006636261);
                chk("abc_w16", rx[16], 64'h8000000000000000);
            end
            if (i == 4) begin
                logic [63:0] w;
                w = rx[16];
                chk("len135_w16_byte7", 64'(w[63:56]), 64'h86);
            end
            if (i == 5) begin
                chk("len136_w17", rx[17], 64'h0000000000000006);
                chk("len136_w33", rx[33], 64'h8000000000000000);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
